window_builder: RTL

WINDOW_BUILDER -- requirements
Module: window_builder

---
 rtl/window_builder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/window_builder.sv
// window_builder: turns a raster pixel stream into 3x3 windows.
// Two line buffers hold the previous two rows; a 3x3 register
// window slides one column per accepted pixel.
//
// Ports:
//   clk          rising-edge clock
//   n_rst        synchronous active-low reset
//   pixel_valid  pixel_in / sof qualify this cycle
//   sof          first pixel of a frame (row 0, col 0)
//   pixel_in     24-bit RGB pixel, raster order
//   pixelData    3x3 window, p0 at [215:192] .. p8 at [23:0]
//   window_valid one-cycle pulse when pixelData is new
//   frame_done   one-cycle pulse with the last window of a frame
module window_builder #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 12
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         pixel_valid,
    input  logic         sof,
    input  logic [23:0]  pixel_in,
    output logic [215:0] pixelData,
    output logic         window_valid,
    output logic         frame_done
);

    localparam int CW = $clog2(IMG_WIDTH) + 1;
    localparam int RW = $clog2(IMG_HEIGHT) + 1;
    localparam int AW = $clog2(IMG_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0] col;
    logic [CW-1:0] col_eff;
    logic [CW-1:0] col_nx;
    logic [RW-1:0] row;
    logic [RW-1:0] row_eff;
    logic [RW-1:0] row_nx;
    logic [AW-1:0] addr;

    logic accept;
    logic last_px;
    logic emit;

    logic [23:0] la [0:IMG_WIDTH-1];
    logic [23:0] lb [0:IMG_WIDTH-1];

    logic [23:0] win    [0:8];
    logic [23:0] win_nx [0:8];
    logic [215:0] pd_nx;

    // sof restarts the position at (0,0) for the pixel that carries it
    always_comb begin
        accept  = pixel_valid && (sof || (state != IDLE));
        col_eff = sof ? '0 : col;
        row_eff = sof ? '0 : row;
        addr    = col_eff[AW-1:0];
        last_px = (row_eff == RW'(IMG_HEIGHT - 1)) &&
                  (col_eff == CW'(IMG_WIDTH - 1));
        emit    = accept && (row_eff >= RW'(2)) &&
                  (col_eff >= CW'(2));
    end

    always_comb begin
        state_nx = state;
        col_nx   = col;
        row_nx   = row;
        if (accept) begin
            if (last_px) begin
                state_nx = IDLE;
                col_nx   = '0;
                row_nx   = '0;
            end else begin
                if (col_eff == CW'(IMG_WIDTH - 1)) begin
                    col_nx = '0;
                    row_nx = row_eff + RW'(1);
                end else begin
                    col_nx = col_eff + CW'(1);
                    row_nx = row_eff;
                end
                state_nx = (row_nx >= RW'(2)) ? RUN : FILL;
            end
        end
    end

    // Shift left one column; new right column comes from the two
    // line buffers (rows r-2, r-1) and the incoming pixel (row r).
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            win_nx[3*i]     = win[3*i + 1];
            win_nx[3*i + 1] = win[3*i + 2];
        end
        win_nx[2] = lb[addr];
        win_nx[5] = la[addr];
        win_nx[8] = pixel_in;
        pd_nx = '0;
        for (int k = 0; k < 9; k++) begin
            pd_nx[215 - 24*k -: 24] = win_nx[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            pixelData    <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win[k] <= '0;
            end
        end else begin
            state        <= state_nx;
            col          <= col_nx;
            row          <= row_nx;
            window_valid <= emit;
            frame_done   <= accept && last_px;
            if (accept) begin
                for (int k = 0; k < 9; k++) begin
                    win[k] <= win_nx[k];
                end
            end
            if (emit) begin
                pixelData <= pd_nx;
            end
        end
    end

    // Line buffers carry no reset; stale contents are never emitted
    always_ff @(posedge clk) begin
        if (n_rst && accept) begin
            lb[addr] <= la[addr];
            la[addr] <= pixel_in;
        end
    end

endmodule
